// File: rtl/sat_accum.sv
// Saturating accumulator: sums LEN signed 6-bit products into an OUT_W-bit clamped result.
// Define SAT_ACCUM_OVF_EN to build the sticky per-group clamp flag; otherwise ovf is tied low.
module sat_accum #(
    parameter int LEN   = 4,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             ovf
);

    localparam int CNT_W = $clog2(LEN);

    typedef enum logic {
        ACC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [OUT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W:0]   sum;
    logic             clamped;
    logic [OUT_W-1:0] sat_val;
    logic             last;
    logic             in_xfer;
    logic             out_xfer;

    // One guard bit is enough: both operands already fit in OUT_W signed bits.
    assign sum     = {acc[OUT_W-1], acc} + {{(OUT_W-5){in_data[5]}}, in_data};
    assign clamped = sum[OUT_W] ^ sum[OUT_W-1];
    assign sat_val = clamped ? {sum[OUT_W], {(OUT_W-1){~sum[OUT_W]}}} : sum[OUT_W-1:0];

    assign last     = (cnt == CNT_W'(LEN - 1));
    assign in_xfer  = in_valid && (state == ACC);
    assign out_xfer = out_ready && (state == DONE);
    assign out_data = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
    end

    // The counter holds at LEN-1 in DONE and is cleared when the result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_xfer) begin
            acc <= sat_val;
            if (!last) begin
                cnt <= cnt + 1'b1;
            end
        end else if (out_xfer) begin
            acc <= '0;
            cnt <= '0;
        end
    end

`ifdef SAT_ACCUM_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_xfer) begin
            ovf_q <= ovf_q | clamped;
        end else if (out_xfer) begin
            ovf_q <= 1'b0;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sat_accum.sv
// Self-checking bench for sat_accum (LEN=4, OUT_W=6) against a plain-integer clamp-per-step model.
// The expected ovf follows SAT_ACCUM_OVF_EN the same way the design build does.
module tb_sat_accum;

    localparam int LEN   = 4;
    localparam int OUT_W = 6;
    localparam int MAXV  = (1 << (OUT_W - 1)) - 1;
    localparam int MINV  = -(1 << (OUT_W - 1));
`ifdef SAT_ACCUM_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             ovf;

    int n_checks = 0;
    int n_fails  = 0;

    sat_accum #(
        .LEN  (LEN),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: running integer sum clamped after every product.
    function automatic void model_group(input int vals[LEN], output int res, output bit flag);
        int s;
        res  = 0;
        flag = 1'b0;
        foreach (vals[i]) begin
            s = res + vals[i];
            if (s > MAXV) begin
                s    = MAXV;
                flag = 1'b1;
            end else if (s < MINV) begin
                s    = MINV;
                flag = 1'b1;
            end
            res = s;
        end
        if (!OVF_EN) flag = 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = 6'(v);
        while (in_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL push_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        n_checks++;
        if ($signed(out_data) !== 0) begin
            n_fails++;
            $display("[TB] FAIL reset_out_data: got %0d, required 0", $signed(out_data));
        end
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_ovf: got %b, required 0", ovf);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int v[LEN];
        int exp_d;
        bit exp_o;
        v = '{10, 20, -5, 3};
        model_group(v, exp_d, exp_o);
        for (int i = 0; i < LEN; i++) begin
            push(v[i]);
            if (i < LEN - 1) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fails++;
                    $display("[TB] FAIL basic_early_valid: after %0d products got %b, required 0", i + 1, out_valid);
                end
            end
        end
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL basic_latency: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
        end
        n_checks++;
        if ($signed(out_data) !== exp_d || ovf !== exp_o) begin
            n_fails++;
            $display("[TB] FAIL basic_result: got %0d ovf=%b, required %0d ovf=%b", $signed(out_data), ovf, exp_d, exp_o);
        end
        drain();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL basic_next_group: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_saturation();
        int tbl[3][LEN];
        int v[LEN];
        int exp_d;
        bit exp_o;
        tbl = '{'{31, 1, -1, 0}, '{-32, -32, -32, -32}, '{1, 1, 1, 1}};
        for (int g = 0; g < 3; g++) begin
            v = tbl[g];
            model_group(v, exp_d, exp_o);
            for (int i = 0; i < LEN; i++) push(v[i]);
            n_checks++;
            if (out_valid !== 1'b1 || $signed(out_data) !== exp_d) begin
                n_fails++;
                $display("[TB] FAIL sat_result_%0d: valid=%b data=%0d, required 1/%0d", g, out_valid, $signed(out_data), exp_d);
            end
            n_checks++;
            if (ovf !== exp_o) begin
                n_fails++;
                $display("[TB] FAIL sat_ovf_%0d: got %b, required %b", g, ovf, exp_o);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int v[LEN];
        int w[LEN];
        int exp_d;
        bit exp_o;
        int held;
        for (int i = 0; i < LEN; i++) v[i] = int'($urandom_range(0, 63)) - 32;
        model_group(v, exp_d, exp_o);
        for (int i = 0; i < LEN; i++) push(v[i]);
        held      = int'($urandom_range(0, 63)) - 32;
        in_valid  = 1'b1;
        in_data   = 6'(held);
        out_ready = 1'b0;
        repeat (5) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || $signed(out_data) !== exp_d || ovf !== exp_o) begin
                n_fails++;
                $display("[TB] FAIL bp_hold: valid=%b ready=%b data=%0d ovf=%b, required 1/0/%0d/%b",
                         out_valid, in_ready, $signed(out_data), ovf, exp_d, exp_o);
            end
        end
        drain();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        w[0] = held;
        for (int i = 1; i < LEN; i++) w[i] = int'($urandom_range(0, 63)) - 32;
        model_group(w, exp_d, exp_o);
        for (int i = 0; i < LEN; i++) push(w[i]);
        n_checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== exp_d || ovf !== exp_o) begin
            n_fails++;
            $display("[TB] FAIL bp_next_group: valid=%b data=%0d ovf=%b, required 1/%0d/%b",
                     out_valid, $signed(out_data), ovf, exp_d, exp_o);
        end
        drain();
    endtask

    task automatic test_bubbles();
        int v[LEN];
        int gaps[LEN];
        int exp_d;
        bit exp_o;
        v    = '{5, 5, 5, 5};
        gaps = '{0, 3, 0, 1};
        model_group(v, exp_d, exp_o);
        for (int i = 0; i < LEN; i++) begin
            in_valid = 1'b0;
            repeat (gaps[i]) begin
                tick();
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fails++;
                    $display("[TB] FAIL bubble_early_valid: before product %0d got %b, required 0", i, out_valid);
                end
            end
            push(v[i]);
        end
        n_checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== exp_d || ovf !== exp_o) begin
            n_fails++;
            $display("[TB] FAIL bubble_result: valid=%b data=%0d ovf=%b, required 1/%0d/%b",
                     out_valid, $signed(out_data), ovf, exp_d, exp_o);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int v[LEN];
        int exp_d;
        bit exp_o;
        push(7);
        push(7);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || $signed(out_data) !== 0 || ovf !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_mid: ready=%b valid=%b data=%0d ovf=%b, required 1/0/0/0",
                     in_ready, out_valid, $signed(out_data), ovf);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        v = '{1, 2, 3, 4};
        model_group(v, exp_d, exp_o);
        for (int i = 0; i < LEN; i++) push(v[i]);
        n_checks++;
        if (out_valid !== 1'b1 || $signed(out_data) !== exp_d || ovf !== exp_o) begin
            n_fails++;
            $display("[TB] FAIL reset_mid_next: valid=%b data=%0d ovf=%b, required 1/%0d/%b",
                     out_valid, $signed(out_data), ovf, exp_d, exp_o);
        end
        // Reset while a result is pending must drop it.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || $signed(out_data) !== 0) begin
            n_fails++;
            $display("[TB] FAIL reset_in_done: valid=%b ready=%b data=%0d, required 0/1/0",
                     out_valid, in_ready, $signed(out_data));
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int v[LEN];
        int exp_d;
        bit exp_o;
        int idle;
        for (int g = 0; g < 25; g++) begin
            for (int i = 0; i < LEN; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    idle     = int'($urandom_range(1, 3));
                    in_valid = 1'b0;
                    in_data  = 6'($urandom);
                    repeat (idle) begin
                        tick();
                        n_checks++;
                        if (out_valid !== 1'b0) begin
                            n_fails++;
                            $display("[TB] FAIL rand_early_valid: group %0d got %b, required 0", g, out_valid);
                        end
                    end
                end
                v[i] = int'($urandom_range(0, 63)) - 32;
                push(v[i]);
            end
            model_group(v, exp_d, exp_o);
            n_checks++;
            if (out_valid !== 1'b1 || $signed(out_data) !== exp_d || ovf !== exp_o) begin
                n_fails++;
                $display("[TB] FAIL rand_result: group %0d valid=%b data=%0d ovf=%b, required 1/%0d/%b",
                         g, out_valid, $signed(out_data), ovf, exp_d, exp_o);
            end
            idle = int'($urandom_range(0, 3));
            repeat (idle) begin
                in_valid = $urandom_range(0, 1) == 1;
                in_data  = 6'($urandom);
                tick();
                n_checks++;
                if (out_valid !== 1'b1 || $signed(out_data) !== exp_d || ovf !== exp_o) begin
                    n_fails++;
                    $display("[TB] FAIL rand_hold: group %0d valid=%b data=%0d ovf=%b, required 1/%0d/%b",
                             g, out_valid, $signed(out_data), ovf, exp_d, exp_o);
                end
            end
            in_valid = 1'b0;
            drain();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
